// File: rtl/fetch_queue_pkg.sv
// Shared CPU definitions for the fetch stage: reset PC, nop encoding and the
// fetch-queue entry layout.
package fetch_queue_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   // A misaligned fetch carries a nop so nothing downstream decodes garbage.
   function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                               input logic [31:0] instr);
      fetch_entry_t e;
      e.pc    = pc;
      e.adel  = (pc[1:0] != 2'b00);
      e.instr = e.adel ? NOP_INSTR : instr;
      return e;
   endfunction

endpackage

// File: rtl/fq_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous
// read port. Cleared on reset.
module fq_ram #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int W     = 65
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: captures {PC, instr} pairs each cycle a slot is free,
// delivers them in order under decode stall, and drives the PC write enable.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_f,
   input  logic [31:0]      instr_f,
   input  logic             flush,
   input  logic             freeze_d,
   output logic             pc_we,
   output logic             d_valid,
   output logic [31:0]      d_pc,
   output logic [31:0]      d_instr,
   output logic             d_adel,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               full;
   logic               enq;
   logic               deq;
   fetch_entry_t       wr_entry;
   fetch_entry_t       rd_entry;
   logic [ENTRY_W-1:0] rd_data;

   assign full     = (count == CNT_W'(DEPTH));
   assign d_valid  = (count != '0);
   // No full-bypass: a slot freed by this cycle's dequeue is reused next cycle.
   assign enq      = ~full & ~flush;
   assign deq      = d_valid & ~freeze_d & ~flush;
   assign pc_we    = flush | ~full;
   assign wr_entry = make_entry(pc_f, instr_f);

   fq_ram #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .W     (ENTRY_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (enq),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign rd_entry = fetch_entry_t'(rd_data);
   assign d_pc     = d_valid ? rd_entry.pc    : 32'h0;
   assign d_instr  = d_valid ? rd_entry.instr : NOP_INSTR;
   assign d_adel   = d_valid & rd_entry.adel;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus side models the PC register
// and queue occupancy, the monitor checks every delivered head entry.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      pc_f;
   logic [31:0]      instr_f;
   logic             flush;
   logic             freeze_d;
   logic             pc_we;
   logic             d_valid;
   logic [31:0]      d_pc;
   logic [31:0]      d_instr;
   logic             d_adel;
   logic [CNT_W-1:0] count;

   fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .pc_f     (pc_f),
      .instr_f  (instr_f),
      .flush    (flush),
      .freeze_d (freeze_d),
      .pc_we    (pc_we),
      .d_valid  (d_valid),
      .d_pc     (d_pc),
      .d_instr  (d_instr),
      .d_adel   (d_adel),
      .count    (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          mcnt   = 0;
   logic [31:0] pc_next;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] imem(input logic [31:0] pc);
      return (pc == 32'h0000_3002) ? 32'h8C01_0000 : (pc ^ 32'hA5A5_0000);
   endfunction

   // Called at posedge+1: checks state left by the last edge, then drives the
   // inputs that the next edge acts on.
   task automatic step(input logic fl, input logic fz, input logic [31:0] tgt);
      logic exp_we, m_enq, m_deq;
      exp_exp_t_dummy: begin end
      chk("count", 32'(count), 32'(mcnt));
      chk("d_valid", 32'(d_valid), 32'(mcnt != 0));
      pc_f     = pc_next;
      instr_f  = imem(pc_next);
      flush    = fl;
      freeze_d = fz;
      exp_we = fl | (mcnt != DEPTH);
      m_enq  = (mcnt != DEPTH) & ~fl;
      m_deq  = (mcnt != 0) & ~fz & ~fl;
      #1;
      chk("pc_we", 32'(pc_we), 32'(exp_we));
      if (fl) begin
         sb.delete();
         mcnt = 0;
      end else begin
         if (m_enq) begin
            exp_t e;
            e.pc    = pc_next;
            e.adel  = (pc_next[1:0] != 2'b00);
            e.instr = e.adel ? 32'h0 : imem(pc_next);
            sb.push_back(e);
         end
         mcnt = mcnt + (m_enq ? 1 : 0) - (m_deq ? 1 : 0);
      end
      if (exp_we) pc_next = fl ? tgt : pc_next + 32'd4;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the head against the scoreboard whenever it is consumed.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (d_valid && !freeze_d && !flush) begin
               if (sb.size() == 0) begin
                  chk("sb_underflow_d_pc", d_pc, 32'hFFFF_FFFF);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("head_pc", d_pc, e.pc);
                  chk("head_instr", d_instr, e.instr);
                  chk("head_adel", 32'(d_adel), 32'(e.adel));
               end
            end else if (!d_valid) begin
               chk("empty_d_pc", d_pc, 32'h0);
               chk("empty_d_instr", d_instr, 32'h0);
               chk("empty_d_adel", 32'(d_adel), 32'h0);
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      freeze_d = 1'b0;
      pc_next  = RESET_PC;
      pc_f     = RESET_PC;
      instr_f  = imem(RESET_PC);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_d_valid", 32'(d_valid), 32'h0);
      chk("rst_pc_we", 32'(pc_we), 32'h1);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_d_pc", d_pc, 32'h0);
      reset = 1'b0;

      // Streaming with no stall: count settles at 1.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
      // Decode stall fills the queue; pc_we drops when full.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);
      chk("full_head_held", d_pc, 32'h0000_3008);
      // One dequeue while full: no enqueue that cycle.
      step(1'b0, 1'b0, 32'h0);
      // Redirect at count 3.
      step(1'b1, 1'b1, 32'h0000_3400);
      chk("post_flush_valid", 32'(d_valid), 32'h0);
      // Build to 2 then run 8 simultaneous enq/deq transfers.
      step(1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
      // Redirect to a misaligned target; its entries carry adel and a nop.
      step(1'b1, 1'b0, 32'h0000_3002);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);
      chk("adel_head", 32'(d_adel), 32'h1);
      chk("adel_instr", d_instr, 32'h0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0);
      chk("pre_reset_count", 32'(count), 32'h3);
      // Asynchronous reset mid-cycle with a non-empty queue.
      #2;
      reset = 1'b1;
      #1;
      chk("async_d_valid", 32'(d_valid), 32'h0);
      chk("async_count", 32'(count), 32'h0);
      chk("async_d_pc", d_pc, 32'h0);
      chk("async_d_instr", d_instr, 32'h0);
      chk("async_d_adel", 32'(d_adel), 32'h0);
      chk("async_pc_we", 32'(pc_we), 32'h1);
      sb.delete();
      mcnt    = 0;
      pc_next = RESET_PC;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
